// File: rtl/wb_pkg.sv
// wb_pkg: shared arbiter state encoding and Wishbone sizing helper
package wb_pkg;
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 1'b0;
  localparam arb_state_t ARB_OWNED = 1'b1;
  function automatic int wb_sel_width(input int data_width, input int granule);
    return data_width / granule;
  endfunction
endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: round-robin pick of the first requester after the last owner
module wb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  // farthest candidate first so the nearest requester after last wins
  always_comb begin
    valid = |req;
    idx = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(last) + i) % N);
      if (req[k]) idx = k;
    end
  end
endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone B4 classic arbiter with optional stall watchdog
module wb_arbiter_rr import wb_pkg::*; #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int GRANULE     = 8,
  parameter int TIMEOUT     = 0,
  localparam int SEL_WIDTH  = wb_sel_width(DATA_WIDTH, GRANULE)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  arb_state_t state;
  logic [IW-1:0] owner, last, next_idx;
  logic [CW-1:0] cnt;
  logic valid, owned, own_cyc, own_stb, tmo;
  wb_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req(m_cyc_i), .last(last), .valid(valid), .idx(next_idx)
  );
  // a phase that times out drops STB for the ERR cycle; a coincident ACK wins
  always_comb begin
    owned = state == ARB_OWNED;
    own_cyc = owned & m_cyc_i[owner];
    own_stb = own_cyc & m_stb_i[owner];
    tmo = (TIMEOUT > 0) && own_stb && !s_ack_i && (int'(cnt) == TIMEOUT - 1);
    grant_o = {{(NUM_MASTERS-1){1'b0}}, owned} << owner;
    m_ack_o = {{(NUM_MASTERS-1){1'b0}}, own_stb & s_ack_i} << owner;
    m_err_o = {{(NUM_MASTERS-1){1'b0}}, tmo} << owner;
    s_cyc_o = own_cyc;
    s_stb_o = own_stb & ~tmo;
    s_we_o = own_cyc & m_we_i[owner];
    s_adr_o = owned ? m_adr_i[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    s_dat_o = owned ? m_dat_i[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
    s_sel_o = owned ? m_sel_i[owner*SEL_WIDTH +: SEL_WIDTH] : '0;
  end
  assign m_dat_o = s_dat_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
      owner <= '0;
      last <= IW'(NUM_MASTERS - 1);
      cnt <= '0;
    end else begin
      if (!owned && valid) begin
        state <= ARB_OWNED;
        owner <= next_idx;
      end
      if (owned && !m_cyc_i[owner]) begin
        state <= ARB_IDLE;
        last <= owner;
      end
      cnt <= (TIMEOUT == 0 || !own_stb || s_ack_i || tmo) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb_wb_arbiter_rr: scoreboard bench with a register slave and per-master bus models
module tb_wb_arbiter_rr;
  localparam int N = 4, AW = 16, DW = 32, SW = 4, TO = 8;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [N-1:0] m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N*SW-1:0] m_sel_i = '0;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i, sreg, keep;
  logic [N-1:0] m_ack_o, m_err_o, grant_o, prev_g;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, mute = 1'b0;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  int vectors = 0, miscompares = 0, run = 0, errs = 0;
  int nph[N], more[N], phases[N], acks[N];
  logic [N-1:0] gq[$];
  logic [DW-1:0] rdq[$];

  always #5 clk_i = ~clk_i;

  wb_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .grant_o(grant_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // single register slave, ACK one cycle after STB; mute makes it stall forever
  always @(posedge clk_i) begin
    if (rst_i) begin
      s_ack_i <= 1'b0;
      sreg <= '0;
    end else begin
      if (s_cyc_o && s_stb_o && s_ack_i && s_we_o)
        for (int b = 0; b < SW; b++) if (s_sel_o[b]) sreg[8*b +: 8] <= s_dat_o[8*b +: 8];
      s_ack_i <= s_cyc_o && s_stb_o && !s_ack_i && !mute;
    end
  end
  assign s_dat_i = sreg;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_g <= '0;
      run <= 0;
    end else begin
      if (grant_o != '0 && grant_o != prev_g) begin
        check("idle_gap", prev_g, 0);
        if (gq.size() == 0) check("grant_extra", grant_o, 0);
        else check("grant_order", grant_o, gq.pop_front());
      end
      if ((m_ack_o | m_err_o) != '0) check("resp_route", m_ack_o | m_err_o, grant_o);
      if (m_err_o != '0) begin
        check("wdg_cycle", run + 1, TO);
        errs <= errs + 1;
      end
      run <= ((m_stb_i & grant_o) != '0 && m_ack_o == '0 && m_err_o == '0) ? run + 1 : 0;
      prev_g <= grant_o;
    end
  end

  task automatic request(input int k, input int n_bus, input int n_ph, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    m_we_i[k] = we;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat;
    m_sel_i[k*SW +: SW] = sel;
    more[k] = n_bus;
    nph[k] = n_ph;
    acks[k] = 0;
  endtask

  // one clock of every master model: responses sampled before the edge, drive after it
  task automatic step();
    logic [N-1:0] a, e;
    @(negedge clk_i);
    a = m_ack_o;
    e = m_err_o;
    for (int k = 0; k < N; k++)
      if (a[k] && !m_we_i[k]) check("read_data", m_dat_o, rdq.size() != 0 ? rdq.pop_front() : 'x);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (!m_cyc_i[k] && more[k] > 0) begin
        more[k]--;
        phases[k] = nph[k];
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'b1;
      end else if (m_cyc_i[k] && (a[k] || e[k])) begin
        acks[k]++;
        phases[k]--;
        if (phases[k] == 0) begin
          m_cyc_i[k] = 1'b0;
          m_stb_i[k] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic busy();
    logic b = (m_cyc_i != '0) || (grant_o != '0);
    for (int k = 0; k < N; k++) if (more[k] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int limit);
    int c = 0;
    while (busy() && c < limit) begin
      step();
      c++;
    end
    check("drain", busy(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_grant", grant_o, 0);
    check("rst_cyc", s_cyc_o, 0);
    check("rst_stb", s_stb_o, 0);
    check("rst_ack", m_ack_o, 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    request(1, 1, 1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    gq.push_back(4'b0010);
    step();
    @(negedge clk_i);
    check("grant_latency", grant_o, 0);
    drain(50);
    check("wr_reg", sreg, 32'hDEADBEEF);
    check("m1_acks", acks[1], 1);

    request(0, 1, 1, 1'b0, 16'h0010, '0, 4'hF);
    rdq.push_back(32'hDEADBEEF);
    gq.push_back(4'b0001);
    drain(50);
    request(2, 1, 1, 1'b1, 16'h0010, 32'h0000_1234, 4'b0011);
    gq.push_back(4'b0100);
    drain(50);
    request(3, 1, 1, 1'b0, 16'h0010, '0, 4'hF);
    rdq.push_back(32'hDEAD_1234);
    gq.push_back(4'b1000);
    drain(50);
    check("sel_reg", sreg, 32'hDEAD_1234);

    for (int k = 0; k < N; k++) request(k, k == 0 ? 2 : 1, 1, 1'b1, AW'(k), 32'hA0 + DW'(k), 4'hF);
    gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    gq.push_back(4'b0100);
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    drain(200);
    check("fair_acks0", acks[0], 2);
    check("fair_acks3", acks[3], 1);

    request(2, 1, 3, 1'b1, 16'h0022, 32'h2222_2222, 4'hF);
    gq.push_back(4'b0100);
    step();
    step();
    request(0, 1, 1, 1'b1, 16'h0000, 32'h0000_0000, 4'hF);
    gq.push_back(4'b0001);
    drain(200);
    check("lock_acks", acks[2], 3);
    check("lock_reg", sreg, 32'h0000_0000);

    keep = sreg;
    mute = 1'b1;
    request(1, 1, 1, 1'b1, 16'h0020, 32'h5555_5555, 4'hF);
    gq.push_back(4'b0010);
    drain(100);
    check("wdg_errs", errs, 1);
    check("wdg_reg", sreg, keep);

    request(3, 1, 1, 1'b0, 16'h0030, '0, 4'hF);
    gq.push_back(4'b1000);
    for (int i = 0; i < 20 && grant_o != 4'b1000; i++) step();
    check("pre_rst_grant", grant_o, 4'b1000);
    step();
    step();
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("mid_rst_grant", grant_o, 0);
    check("mid_rst_cyc", s_cyc_o, 0);
    check("mid_rst_stb", s_stb_o, 0);
    check("mid_rst_resp", m_ack_o | m_err_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mute = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    for (int k = 0; k < N; k++) more[k] = 0;
    request(3, 1, 1, 1'b1, 16'h0030, 32'h3333_3333, 4'hF);
    request(0, 1, 1, 1'b1, 16'h0000, 32'h0F0F_0F0F, 4'hF);
    gq.push_back(4'b0001);
    gq.push_back(4'b1000);
    drain(100);
    check("post_rst_reg", sreg, 32'h3333_3333);
    check("grants_left", gq.size(), 0);
    check("reads_left", rdq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
